// File: rtl/fir_interp2_synth_if.sv
// Stream interface for the 2x interpolating FIR: one input stream (x) and
// one output stream (y), each with a valid/ready handshake.
interface fir_interp2_synth_if;
  logic signed [15:0] x_in;
  logic               x_valid;
  logic               x_ready;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               y_ready;

  // Filter side: consumes x, produces y.
  modport slave (
    input  x_in, x_valid, y_ready,
    output x_ready, y_out, y_valid
  );

  // Source/sink side: produces x, consumes y.
  modport master (
    output x_in, x_valid, y_ready,
    input  x_ready, y_out, y_valid
  );
endinterface

// File: rtl/fir_interp2_synth.sv
// 2x interpolating polyphase FIR (synthesis side of the 9-tap symmetric bank).
// One input sample yields an even output (5 taps) and an odd output (4 taps),
// computed with a single shared multiplier and a serial accumulator.
// The product is registered before accumulation, so a phase of N taps takes
// N+1 cycles from its start to the output load.
module fir_interp2_synth #(
  parameter logic signed [15:0] H0       = 16'sd6,
  parameter logic signed [15:0] H1       = 16'sd12,
  parameter logic signed [15:0] H2       = 16'sd16,
  parameter logic signed [15:0] H3       = 16'sd20,
  parameter logic signed [15:0] H4       = 16'sd106,
  parameter int unsigned        SHIFT    = 32'd0,
  parameter bit                 SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  fir_interp2_synth_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC_E = 3'd1,
    S_OUT_E = 3'd2,
    S_MAC_O = 3'd3,
    S_OUT_O = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic signed [15:0] r_hist [5];
  logic signed [35:0] r_acc;
  logic signed [31:0] r_prod;
  logic [2:0]         r_tap;
  logic signed [15:0] r_y_out;
  logic               r_y_valid;
  logic               r_x_ready;

  logic               w_accept;
  logic               w_y_hs;
  logic               w_mac;
  logic               w_last;
  logic               w_clr;
  logic               w_y_valid_nxt;
  logic               w_x_ready_nxt;
  logic [3:0]         w_k_idx;
  logic signed [15:0] w_coef;
  logic signed [15:0] w_sample;
  logic signed [31:0] w_prod;
  logic signed [35:0] w_sum;

  // Kernel k[0..8] = {-H4, H3, -H2, H1, H0, H1, -H2, H3, -H4}
  function automatic logic signed [15:0] f_kernel(input logic [3:0] idx);
    logic signed [15:0] k;
    case (idx)
      4'd0, 4'd8: k = -H4;
      4'd1, 4'd7: k = H3;
      4'd2, 4'd6: k = -H2;
      4'd3, 4'd5: k = H1;
      4'd4:       k = H0;
      default:    k = 16'sd0;
    endcase
    return k;
  endfunction

  // Arithmetic shift, then either clamp to int16 or keep the low 16 bits
  function automatic logic signed [15:0] f_format(input logic signed [35:0] acc);
    logic signed [35:0] sh;
    logic signed [15:0] y;
    sh = acc >>> SHIFT;
    if (SATURATE) begin
      if (sh > 36'sd32767) begin
        y = 16'sh7fff;
      end else if (sh < -36'sd32768) begin
        y = 16'sh8000;
      end else begin
        y = sh[15:0];
      end
    end else begin
      y = sh[15:0];
    end
    return y;
  endfunction

  assign w_accept = bus.x_valid & r_x_ready;
  assign w_y_hs   = r_y_valid & bus.y_ready;
  assign w_mac    = (r_state == S_MAC_E) || (r_state == S_MAC_O);
  // Tap counter reaches N once all N products have been issued; the last
  // product is still in r_prod and is folded in by w_sum at the load.
  assign w_last   = ((r_state == S_MAC_E) && (r_tap == 3'd5)) ||
                    ((r_state == S_MAC_O) && (r_tap == 3'd4));
  // Even phase uses k[2t], odd phase uses k[2t+1]; both use x[n-t]
  assign w_k_idx  = {r_tap, 1'b0} + {3'b000, (r_state == S_MAC_O)};
  assign w_coef   = f_kernel(w_k_idx);
  assign w_prod   = 32'(w_coef) * 32'(w_sample);
  assign w_sum    = r_acc + 36'(r_prod);

  // Select the history entry for the current tap (zero past the end)
  always_comb begin
    case (r_tap)
      3'd0:    w_sample = r_hist[0];
      3'd1:    w_sample = r_hist[1];
      3'd2:    w_sample = r_hist[2];
      3'd3:    w_sample = r_hist[3];
      3'd4:    w_sample = r_hist[4];
      default: w_sample = 16'sd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_accept ? S_MAC_E : S_IDLE;
      S_MAC_E: w_next_state = w_last   ? S_OUT_E : S_MAC_E;
      S_OUT_E: w_next_state = w_y_hs   ? S_MAC_O : S_OUT_E;
      S_MAC_O: w_next_state = w_last   ? S_OUT_O : S_MAC_O;
      S_OUT_O: w_next_state = w_y_hs   ? S_IDLE  : S_OUT_O;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode: accumulator clear and next values of the handshake flags
  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      S_IDLE:  w_clr = w_accept;
      S_OUT_E: w_clr = w_y_hs;
      default: w_clr = 1'b0;
    endcase
    w_y_valid_nxt = (w_next_state == S_OUT_E) || (w_next_state == S_OUT_O);
    w_x_ready_nxt = (w_next_state == S_IDLE);
  end

  // Datapath: history shift, serial MAC, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_hist[i] <= 16'sd0;
      end
      r_acc     <= 36'sd0;
      r_prod    <= 32'sd0;
      r_tap     <= 3'd0;
      r_y_out   <= 16'sd0;
      r_y_valid <= 1'b0;
      r_x_ready <= 1'b0;
    end else begin
      r_x_ready <= w_x_ready_nxt;
      r_y_valid <= w_y_valid_nxt;
      if (w_accept) begin
        r_hist[0] <= bus.x_in;
        for (int i = 1; i < 5; i++) begin
          r_hist[i] <= r_hist[i-1];
        end
      end
      if (w_clr) begin
        r_acc  <= 36'sd0;
        r_prod <= 32'sd0;
        r_tap  <= 3'd0;
      end else if (w_mac) begin
        r_acc  <= w_sum;
        r_prod <= w_prod;
        r_tap  <= r_tap + 3'd1;
      end
      if (w_last) begin
        r_y_out <= f_format(w_sum);
      end
    end
  end

  assign bus.x_ready = r_x_ready;
  assign bus.y_out   = r_y_out;
  assign bus.y_valid = r_y_valid;

endmodule

// File: tb/tb_fir_interp2_synth.sv
// Bench for fir_interp2_synth: two instances driven in lockstep, one wrapping
// (SHIFT=0) and one saturating (SHIFT=2), checked against a convolution model
// of the upsampled stream.
module tb_fir_interp2_synth;

  logic               clk = 1'b0;
  logic               tb_rst;
  logic signed [15:0] tb_x;
  logic               tb_xv;
  logic               tb_yr;
  int                 cyc = 0;
  int                 n_vec = 0;
  int                 n_err = 0;
  int                 xq[$];
  int                 got_e_w, got_o_w, got_e_s, got_o_s;

  fir_interp2_synth_if bus_w ();
  fir_interp2_synth_if bus_s ();

  assign bus_w.x_in    = tb_x;
  assign bus_w.x_valid = tb_xv;
  assign bus_w.y_ready = tb_yr;
  assign bus_s.x_in    = tb_x;
  assign bus_s.x_valid = tb_xv;
  assign bus_s.y_ready = tb_yr;

  fir_interp2_synth dut_w (
    .clk (clk),
    .rst (tb_rst),
    .bus (bus_w)
  );

  fir_interp2_synth #(.SHIFT(32'd2), .SATURATE(1'b1)) dut_s (
    .clk (clk),
    .rst (tb_rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y[m] = sum k[i]*u[m-i], u[2n]=x[n], u[2n+1]=0, then shift and wrap/clamp
  function automatic int ref_y(input int m, input bit sat, input int sh);
    int     k [9] = '{-106, 20, -16, 12, 6, 12, -16, 20, -106};
    longint acc;
    longint v;
    int     j;
    logic signed [15:0] w;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      j = m - i;
      if (j >= 0 && (j % 2) == 0) acc += longint'(k[i]) * longint'(xq[j/2]);
    end
    v = acc >>> sh;
    if (sat) begin
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
    end
    w = v[15:0];
    return int'(w);
  endfunction

  task automatic wait_valid(input string tag);
    int w = 0;
    while (bus_w.y_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid_w"}, longint'(bus_w.y_valid), 1);
    chk({tag, "_valid_s"}, longint'(bus_s.y_valid), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_yout"},  longint'(bus_w.y_out), 0);
    chk({tag, "_yvalid"}, longint'(bus_w.y_valid), 0);
    chk({tag, "_xready"}, longint'(bus_w.x_ready), 0);
    chk({tag, "_xready_s"}, longint'(bus_s.x_ready), 0);
  endtask

  // Called at a negedge; pushes one sample and consumes both outputs.
  // x_valid is left high afterwards (it must be ignored outside IDLE).
  task automatic run_sample(input logic signed [15:0] x, input int st_e, input int st_o);
    int t_acc, t_hs, n, w, ev_w, ev_s, od_w, od_s;
    tb_x = x; tb_xv = 1'b1; tb_yr = (st_e == 0);
    w = 0;
    while (bus_w.x_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", longint'(bus_w.x_ready), 1);
    xq.push_back(int'(x));
    n = xq.size() - 1;
    ev_w = ref_y(2*n, 1'b0, 0);   ev_s = ref_y(2*n, 1'b1, 2);
    od_w = ref_y(2*n+1, 1'b0, 0); od_s = ref_y(2*n+1, 1'b1, 2);
    t_acc = cyc + 1;
    @(negedge clk);
    wait_valid("even");
    chk("lat_even", cyc - t_acc, 6);
    chk("even_w", longint'(bus_w.y_out), ev_w);
    chk("even_s", longint'(bus_s.y_out), ev_s);
    got_e_w = int'(bus_w.y_out); got_e_s = int'(bus_s.y_out);
    for (int i = 0; i < st_e; i++) begin
      @(negedge clk);
      chk("hold_even_valid", longint'(bus_w.y_valid), 1);
      chk("hold_even_y", longint'(bus_w.y_out), ev_w);
      chk("hold_even_xready", longint'(bus_w.x_ready), 0);
    end
    tb_yr = 1'b1;
    t_hs = cyc + 1;
    @(negedge clk);
    chk("drop_even", longint'(bus_w.y_valid), 0);
    tb_yr = (st_o == 0);
    wait_valid("odd");
    chk("lat_odd", cyc - t_hs, 5);
    chk("odd_w", longint'(bus_w.y_out), od_w);
    chk("odd_s", longint'(bus_s.y_out), od_s);
    got_o_w = int'(bus_w.y_out); got_o_s = int'(bus_s.y_out);
    for (int i = 0; i < st_o; i++) begin
      @(negedge clk);
      chk("hold_odd_y", longint'(bus_w.y_out), od_w);
      chk("hold_odd_xready", longint'(bus_w.x_ready), 0);
    end
    tb_yr = 1'b1;
    @(negedge clk);
    chk("drop_odd", longint'(bus_w.y_valid), 0);
    chk("ready_back", longint'(bus_w.x_ready), 1);
    if (st_e == 0 && st_o == 0) chk("accept_to_ready", cyc - t_acc, 13);
  endtask

  task automatic impulse_run(input string tag);
    int imp [10] = '{-106, 20, -16, 12, 6, 12, -16, 20, -106, 0};
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? 16'sd1 : 16'sd0, 0, 0);
      chk({tag, "_even"}, got_e_w, imp[2*i]);
      chk({tag, "_odd"},  got_o_w, imp[2*i+1]);
    end
  endtask

  initial begin
    logic [31:0] r32;
    int          nv;
    int          se, so;
    tb_rst = 1'b1; tb_x = 16'sd0; tb_xv = 1'b0; tb_yr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    tb_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", longint'(bus_w.x_ready), 1);

    impulse_run("impulse");

    for (int i = 0; i < 6; i++) begin
      run_sample(16'sd100, 0, 0);
      if (i >= 4) begin
        chk("dc_even", got_e_w, -23800);
        chk("dc_odd",  got_o_w, 6400);
      end
    end

    for (int i = 0; i < 6; i++) begin
      run_sample(16'sd32767, 0, 0);
      if (i >= 4) begin
        chk("ovf_wrap_even", got_e_w, 238);
        chk("ovf_wrap_odd",  got_o_w, -64);
        chk("ovf_sat_even",  got_e_s, -32768);
        chk("ovf_sat_odd",   got_o_s, 32767);
      end
    end

    r32 = $urandom;
    run_sample(r32[15:0], 10, 0);

    for (int i = 0; i < 30; i++) begin
      r32 = $urandom;
      se = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      so = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_sample(r32[15:0], se, so);
    end

    // Reset three cycles after an accept: the sample must vanish
    tb_x = 16'sd1234; tb_xv = 1'b1;
    nv = 0;
    while (bus_w.x_ready !== 1'b1 && nv < 40) begin
      @(negedge clk);
      nv++;
    end
    chk("rst_test_ready", longint'(bus_w.x_ready), 1);
    @(negedge clk);
    tb_xv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tb_rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    tb_rst = 1'b0;
    xq.delete();
    @(negedge clk);
    chk("ready_after_midrst", longint'(bus_w.x_ready), 1);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_w.y_valid === 1'b1 || bus_s.y_valid === 1'b1) nv++;
      @(negedge clk);
    end
    chk("no_valid_after_rst", nv, 0);

    impulse_run("impulse_after_rst");
    tb_xv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
